// File: rtl/stream_light_ctrl.sv
// stream_light_ctrl: debounced run/stop/dir buttons driving a 4-state LED shifter controller.
// Optional idle auto-power-off from PAUSE when STREAM_LIGHT_IDLE_TIMEOUT_EN is defined.
module stream_light_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TIMEOUT_CYCLES  = 500000000
) (
  input  logic       CLK_in,
  input  logic       Reset_n,
  input  logic       btn_run,
  input  logic       btn_stop,
  input  logic       btn_dir,
  output logic       Run,
  output logic       Reset,
  output logic       Stop,
  output logic       Reverse,
  output logic [1:0] state
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {OFF, INIT, RUN, PAUSE} st_t;
  st_t cur, nxt;
  logic rev, rev_nxt, tmo;
  logic [2:0] raw, s1, s2, deb, deb_q, press;
  logic [CW-1:0] cnt [3];
  assign raw = {btn_dir, btn_stop, btn_run};
  always_ff @(posedge CLK_in or negedge Reset_n)
    if (!Reset_n) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_q <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < 3; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
    end
`ifdef STREAM_LIGHT_IDLE_TIMEOUT_EN
  logic [31:0] idle;
  always_ff @(posedge CLK_in or negedge Reset_n)
    if (!Reset_n) idle <= '0;
    else idle <= (cur == PAUSE) ? idle + 32'd1 : 32'd0;
  assign tmo = (cur == PAUSE) && (idle == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif
  always_ff @(posedge CLK_in or negedge Reset_n)
    if (!Reset_n) begin
      cur <= OFF;
      rev <= 1'b0;
    end else begin
      cur <= nxt;
      rev <= rev_nxt;
    end
  // run > stop > timeout > dir; lower-priority presses are simply discarded
  always_comb begin
    nxt = cur;
    rev_nxt = rev;
    case (cur)
      OFF:  nxt = press[0] ? INIT : OFF;
      INIT: nxt = RUN;
      default:
        if (press[0]) nxt = OFF;
        else if (press[1]) nxt = (cur == RUN) ? PAUSE : RUN;
        else if (tmo) nxt = OFF;
        else if (press[2]) rev_nxt = ~rev;
    endcase
    if (nxt == OFF) rev_nxt = 1'b0;
  end
  assign Run = cur != OFF;
  assign Reset = cur == INIT;
  assign Stop = cur == PAUSE;
  assign Reverse = rev;
  assign state = cur;
endmodule

// File: tb/tb_stream_light_ctrl.sv
// tb_stream_light_ctrl: directed + random button stimulus against a press-event model of the controller.
module tb_stream_light_ctrl;
  localparam int D = 4, TO = 20;
`ifdef STREAM_LIGHT_IDLE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] btn = 3'b0;
  logic run_o, reset_o, stop_o, rev_o;
  logic [1:0] state;
  int n = 0, tests = 0, fails = 0;
  int ms = 0, pause_at = 0;
  bit mrev = 1'b0;
  bit [2:0] act [int];
  always #5 clk = ~clk;
  stream_light_ctrl #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TO)) dut (
    .CLK_in(clk), .Reset_n(rst_n),
    .btn_run(btn[0]), .btn_stop(btn[1]), .btn_dir(btn[2]),
    .Run(run_o), .Reset(reset_o), .Stop(stop_o), .Reverse(rev_o), .state(state)
  );
  // a clean press acts exactly D+4 edges after the raw rise
  function automatic void model_edge();
    bit [2:0] m;
    int ns;
    bit nr;
    if (!rst_n) begin
      ms = 0;
      mrev = 1'b0;
      return;
    end
    m = act.exists(n) ? act[n] : 3'b0;
    ns = ms;
    nr = mrev;
    if (ms == 0) ns = m[0] ? 1 : 0;
    else if (ms == 1) ns = 2;
    else if (m[0]) ns = 0;
    else if (m[1]) ns = (ms == 2) ? 3 : 2;
    else if (TMO_EN && ms == 3 && n - pause_at == TO) ns = 0;
    else if (m[2]) nr = !nr;
    if (ns == 3 && ms != 3) pause_at = n;
    if (ns == 0) nr = 1'b0;
    ms = ns;
    mrev = nr;
  endfunction
  task automatic check();
    logic [5:0] obs, exp;
    obs = {state, run_o, reset_o, stop_o, rev_o};
    exp = {ms[1:0], ms != 0, ms == 1, ms == 3, mrev};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL outputs edge=%0d observed={st,Run,Rst,Stop,Rev}=%b expected=%b", n, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check();
  endtask
  task automatic press(input bit [2:0] m, input int h, input int gap);
    btn = m;
    if (h >= D) act[n + D + 4] = (act.exists(n + D + 4) ? act[n + D + 4] : 3'b0) | m;
    repeat (h) tick();
    btn = 3'b0;
    repeat (gap) tick();
  endtask
  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    press(3'b001, 10, 10);
    press(3'b010, 3, 8);
    press(3'b010, 10, 8);
    press(3'b010, 10, 8);
    press(3'b100, 6, 8);
    press(3'b001, 6, 8);
    press(3'b001, 6, 8);
    press(3'b011, 6, 8);
    press(3'b001, 4, 8);
    press(3'b100, 3, 8);
    for (int i = 0; i < 40; i++) begin
      int r, h;
      bit [2:0] m;
      r = int'($urandom_range(0, 9));
      m = r < 2 ? 3'b001 : r < 5 ? 3'b010 : r < 8 ? 3'b100 : r == 8 ? 3'b011 : 3'($urandom_range(1, 7));
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 9));
      press(m, h, int'($urandom_range(6, 12)));
    end
    rst_n = 1'b0;
    act.delete();
    tick();
    rst_n = 1'b1;
    press(3'b001, 6, 8);
    press(3'b100, 6, 8);
    press(3'b010, 6, 8);
    #2 rst_n = 1'b0;
    #1;
    ms = 0;
    mrev = 1'b0;
    act.delete();
    check();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    press(3'b001, 6, 8);
    press(3'b010, 6, 0);
    repeat (100) tick();
    tests++;
    assert (state === (TMO_EN ? 2'd0 : 2'd3)) else begin
      fails++;
      $error("FAIL pause_dwell observed=%0d expected=%0d", state, TMO_EN ? 0 : 3);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
